// File: rtl/mont_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier between NREQ requesters.
// One operation is in flight at a time; a requester is re-served only after it drops req.
module mont_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 381,
  parameter int GW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_m,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              mm_start,
  output logic [W-1:0]      mm_a,
  output logic [W-1:0]      mm_b,
  output logic [W-1:0]      mm_m,
  input  logic              mm_done,
  input  logic [W-1:0]      mm_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int JW = GW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   served_q, served_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      m_q, m_d;
  logic [W-1:0]      result_q, result_d;

  logic [NREQ-1:0]   elig;
  logic              sel_found;
  logic [GW-1:0]     sel_idx;
  logic [JW-1:0]     jj;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  assign elig = req & ~served_q;

  // Circular search starting at ptr: first eligible index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    jj        = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj = {1'b0, ptr_q} + JW'(k);
      if (jj >= JW'(NREQ)) jj = jj - JW'(NREQ);
      if (!sel_found && elig[jj[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = jj[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    served_d = served_q & req;
    grant_d  = grant_q;
    busy_d   = busy_q;
    done_d   = '0;
    start_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gidx_d  = sel_idx;
          grant_d = onehot(sel_idx);
          busy_d  = 1'b1;
          start_d = 1'b1;
          a_d     = op_a[int'(sel_idx)*W +: W];
          b_d     = op_b[int'(sel_idx)*W +: W];
          m_d     = op_m[int'(sel_idx)*W +: W];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mm_done) begin
          result_d = mm_result;
          done_d   = onehot(gidx_q);
          state_d  = RESP;
        end
      end
      RESP: begin
        // A requester that already dropped req must not stay masked.
        served_d = (served_q | grant_q) & req;
        ptr_d    = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
        grant_d  = '0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      served_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      served_q <= served_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign mm_start = start_q;
  assign mm_a     = a_q;
  assign mm_b     = b_q;
  assign mm_m     = m_q;

endmodule
